bip_fetch_sequencer: RTL

//  Instruction-fetch and run sequencer that sits directly upstream of the BIP control block.
//  It reads instruction words from the synchronous program BRAM at the control block's Addr,

---
 rtl/bip_fetch_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/bip_fetch_sequencer.sv
// Fetch/run sequencer for the BIP control block: reads the program BRAM, holds the
// instruction register and issues the one-cycle execute enable (start_bip).
module bip_fetch_sequencer #(
   parameter int AB = 11,
   parameter int IW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          step_mode,
   input  logic [AB-1:0] Addr,
   output logic [AB-1:0] mem_addr,
   input  logic [IW-1:0] mem_data,
   output logic [4:0]    OpCode,
   output logic [AB-1:0] Operand,
   output logic          start_bip,
   output logic          running,
   output logic          halted,
   output logic [CW-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_LATCH     = 3'd2,
      S_EXEC      = 3'd3,
      S_STEP_WAIT = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [IW-1:0] r_ir;
   logic          r_start_bip;
   logic          r_running;
   logic          r_halted;
   logic [CW-1:0] r_count;
   logic          w_halt_op;
   logic          w_ir_load;
   logic          w_count_inc;

   assign w_halt_op   = (mem_data[IW-1:IW-5] == 5'b00000);
   assign w_ir_load   = (r_state == S_LATCH) && !w_halt_op;
   assign w_count_inc = (r_state == S_EXEC) && (r_count != {CW{1'b1}});

   // Next-state decode; start is only honoured in IDLE and STEP_WAIT
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = S_ISSUE;
            else       w_next_state = S_IDLE;
         end
         S_ISSUE: w_next_state = S_LATCH;
         S_LATCH: begin
            if (w_halt_op) w_next_state = S_HALT;
            else           w_next_state = S_EXEC;
         end
         S_EXEC: begin
            if (step_mode) w_next_state = S_STEP_WAIT;
            else           w_next_state = S_ISSUE;
         end
         S_STEP_WAIT: begin
            if (start) w_next_state = S_ISSUE;
            else       w_next_state = S_STEP_WAIT;
         end
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Status flags are decoded from the next state so they line up with r_state
   // while still coming straight from flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_bip <= 1'b0;
         r_running   <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_start_bip <= (w_next_state == S_EXEC);
         r_running   <= (w_next_state == S_ISSUE) || (w_next_state == S_LATCH) ||
                        (w_next_state == S_EXEC)  || (w_next_state == S_STEP_WAIT);
         r_halted    <= (w_next_state == S_HALT);
      end
   end

   // Instruction register: a HALT word is never loaded, so the last real instruction stays visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_ir <= {IW{1'b0}};
      else if (w_ir_load) r_ir <= mem_data;
      else                r_ir <= r_ir;
   end

   // Saturating executed-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_count <= {CW{1'b0}};
      else if (w_count_inc) r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
      else                  r_count <= r_count;
   end

   assign mem_addr    = Addr;
   assign OpCode      = r_ir[IW-1:IW-5];
   assign Operand     = r_ir[AB-1:0];
   assign start_bip   = r_start_bip;
   assign running     = r_running;
   assign halted      = r_halted;
   assign instr_count = r_count;

endmodule
